// File: rtl/sound_scheduler.sv
// Priority sound scheduler: latches requests, plays one sound at a time for a fixed
// number of frames with a silent gap. Optional preemption via SOUND_SCHEDULER_PREEMPT_EN.
module sound_scheduler #(
   parameter int NUM_REQ         = 4,
   parameter int ID_WIDTH        = 2,
   parameter int DURATION_FRAMES = 8,
   parameter int GAP_FRAMES      = 1
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                enable,
   input  logic                startOfFrame,
   input  logic [NUM_REQ-1:0]  sound_requests,
   output logic [ID_WIDTH-1:0] sound_id,
   output logic                sound_active,
   output logic                sound_start,
   output logic [NUM_REQ-1:0]  pending
);

   // state | meaning
   // IDLE  | no sound; grants the best candidate as soon as one exists
   // PLAY  | sound_id audible, counter holds frames left to play
   // GAP   | silence between sounds, counter holds frames left of gap
   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  pending_q, pending_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic                start_q, start_d;

   logic [NUM_REQ-1:0]  req_en;
   logic [NUM_REQ-1:0]  cand;
   logic [NUM_REQ-1:0]  win_mask;
   logic [ID_WIDTH-1:0] winner;
   logic                grant;
   logic                preempt;

   always_comb begin
      req_en   = enable ? sound_requests : '0;
      cand     = pending_q | req_en;
      winner   = '0;
      win_mask = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            winner      = ID_WIDTH'(i);
            win_mask    = '0;
            win_mask[i] = 1'b1;
         end
      end
`ifdef SOUND_SCHEDULER_PREEMPT_EN
      preempt = (state_q == PLAY) && (|cand) && (winner < id_q);
`else
      preempt = 1'b0;
`endif
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      id_d      = id_q;
      start_d   = 1'b0;
      grant     = 1'b0;
      if (enable) begin
         // a request for the sound now playing stays latched and replays later
         pending_d = cand;
         case (state_q)
            IDLE: grant = |cand;
            PLAY: begin
               if (preempt) begin
                  grant = 1'b1;
               end else if (startOfFrame) begin
                  if (cnt_q == 8'd1) begin
                     if (GAP_FRAMES == 0) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                     end else begin
                        state_d = GAP;
                        cnt_d   = 8'(GAP_FRAMES);
                     end
                  end else begin
                     cnt_d = cnt_q - 8'd1;
                  end
               end
            end
            GAP: begin
               if (startOfFrame) begin
                  if (cnt_q == 8'd1) begin
                     state_d = IDLE;
                     cnt_d   = 8'd0;
                  end else begin
                     cnt_d = cnt_q - 8'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
         if (grant) begin
            state_d   = PLAY;
            cnt_d     = 8'(DURATION_FRAMES);
            id_d      = winner;
            start_d   = 1'b1;
            pending_d = cand & ~win_mask;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         pending_q <= '0;
         id_q      <= '0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         id_q      <= id_d;
         start_q   <= start_d;
      end
   end

   assign sound_id     = id_q;
   assign sound_active = (state_q == PLAY) && enable;
   assign sound_start  = start_q && enable;
   assign pending      = pending_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench for sound_scheduler: expected grant ids are queued when requests are
// driven and popped on every sound_start; a second instance runs with no gap frames.
module tb_sound_scheduler;

   logic       clk = 1'b0;
   logic       resetN;
   logic       enable;
   logic       sof;
   logic [3:0] req;
   logic [3:0] req2;

   logic [1:0] sound_id,  sound_id2;
   logic       active,    active2;
   logic       start,     start2;
   logic [3:0] pending,   pending2;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];
   int exp_q2[$];

   sound_scheduler u_dut (
      .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(sof),
      .sound_requests(req), .sound_id(sound_id), .sound_active(active),
      .sound_start(start), .pending(pending)
   );

   sound_scheduler #(.GAP_FRAMES(0)) u_dut_nogap (
      .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(sof),
      .sound_requests(req2), .sound_id(sound_id2), .sound_active(active2),
      .sound_start(start2), .pending(pending2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      sof = 1'b1;
      step();
      sof = 1'b0;
      step();
   endtask

   always @(negedge clk) begin
      if (start) begin
         check("sb_avail", (exp_q.size() > 0) ? 1 : 0, 1);
         if (exp_q.size() > 0) check("sb_id", int'(sound_id), exp_q.pop_front());
      end
      if (start2) begin
         check("sb2_avail", (exp_q2.size() > 0) ? 1 : 0, 1);
         if (exp_q2.size() > 0) check("sb2_id", int'(sound_id2), exp_q2.pop_front());
      end
   end

   initial begin
      resetN = 1'b0;
      enable = 1'b1;
      sof    = 1'b0;
      req    = '0;
      req2   = '0;
      repeat (3) step();
      check("rst_id", sound_id, 0);
      check("rst_active", active, 0);
      check("rst_start", start, 0);
      check("rst_pending", pending, 0);
      resetN = 1'b1;
      step();

      // single request: one-cycle latency, 8 frames, 1 gap frame
      exp_q.push_back(2);
      req = 4'b0100;
      step();
      req = '0;
      check("a_active", active, 1);
      check("a_start", start, 1);
      check("a_pending", pending, 0);
      step();
      check("a_start_pulse", start, 0);
      for (int f = 1; f <= 8; f++) begin
         frame();
         check($sformatf("a_frame%0d", f), active, (f < 8) ? 1 : 0);
      end
      check("a_gap_id", sound_id, 2);
      frame();
      check("a_idle", active, 0);

      // two simultaneous requests served in priority order
      exp_q.push_back(1);
      exp_q.push_back(3);
      req = 4'b1010;
      step();
      req = '0;
      check("b_id", sound_id, 1);
      check("b_pending", pending, 4'b1000);
      for (int f = 1; f <= 8; f++) begin
         frame();
         check($sformatf("b_frame%0d", f), active, (f < 8) ? 1 : 0);
      end
      frame();
      check("b_id3", sound_id, 3);
      check("b_start3", start, 1);
      check("b_pending0", pending, 0);
      repeat (9) frame();
      check("b_done", active, 0);

      // higher-priority request while id 3 plays
      exp_q.push_back(3);
      req = 4'b1000;
      step();
      req = '0;
      repeat (3) frame();
`ifdef SOUND_SCHEDULER_PREEMPT_EN
      exp_q.push_back(0);
      req = 4'b0001;
      step();
      req = '0;
      check("c_pre_id", sound_id, 0);
      check("c_pre_start", start, 1);
      check("c_pre_pending", pending, 0);
`else
      req = 4'b0001;
      step();
      req = '0;
      check("c_wait_id", sound_id, 3);
      check("c_wait_pending", pending, 4'b0001);
      for (int f = 1; f <= 5; f++) begin
         frame();
         check($sformatf("c_frame%0d", f), active, (f < 5) ? 1 : 0);
      end
      exp_q.push_back(0);
      frame();
      check("c_id0", sound_id, 0);
      check("c_pending0", pending, 0);
`endif
      repeat (9) frame();
      check("c_done", active, 0);

      // pause after 3 frames, resume for the remaining 5
      exp_q.push_back(1);
      req = 4'b0010;
      step();
      req = '0;
      repeat (3) frame();
      enable = 1'b0;
      step();
      check("d_paused_active", active, 0);
      req = 4'b0100;
      step();
      req = '0;
      repeat (2) frame();
      check("d_paused_pending", pending, 0);
      check("d_paused_start", start, 0);
      enable = 1'b1;
      step();
      check("d_resume_active", active, 1);
      check("d_resume_id", sound_id, 1);
      for (int f = 1; f <= 5; f++) begin
         frame();
         check($sformatf("d_frame%0d", f), active, (f < 5) ? 1 : 0);
      end
      frame();

      // reset mid-play with pending work
      exp_q.push_back(0);
      req = 4'b0111;
      step();
      req = '0;
      check("e_pending", pending, 4'b0110);
      repeat (2) frame();
      resetN = 1'b0;
      req    = 4'b1000;
      step();
      check("e_rst_id", sound_id, 0);
      check("e_rst_active", active, 0);
      check("e_rst_start", start, 0);
      check("e_rst_pending", pending, 0);
      resetN = 1'b1;
      req    = '0;
      repeat (5) frame();
      check("e_silent", active, 0);
      check("e_silent_pending", pending, 0);

      // zero-gap instance: next sound starts one cycle after the fall
      exp_q2.push_back(0);
      exp_q2.push_back(1);
      req2 = 4'b0011;
      step();
      req2 = '0;
      check("f_id0", sound_id2, 0);
      check("f_pending", pending2, 4'b0010);
      repeat (7) frame();
      check("f_still", active2, 1);
      sof = 1'b1;
      step();
      sof = 1'b0;
      check("f_fall", active2, 0);
      check("f_fall_start", start2, 0);
      step();
      check("f_start1", start2, 1);
      check("f_id1", sound_id2, 1);
      check("f_active1", active2, 1);
      repeat (8) frame();
      check("f_done", active2, 0);

      step();
      check("sb_empty", exp_q.size(), 0);
      check("sb2_empty", exp_q2.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
